// File: rtl/debounce_pkg.sv
// Shared definitions for the two-channel input debouncer.
package debounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    PEND   = 1'b1
  } deb_state_e;

  localparam int unsigned DEB_CNT_W         = 16;
  localparam int unsigned DEB_STABLE_CYCLES = 1000;

endpackage

// File: rtl/debounce_ch.sv
// Single-channel debouncer: two-flop synchroniser, stability counter and level/edge outputs.
// Edge pulse registers exist only when DEBOUNCE_AB_EDGE_EN is defined.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W         = DEB_CNT_W,
  parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  deb_state_e       state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= STABLE;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    unique case (state_q)
      STABLE: begin
        if (s2_q != level_q) begin
          if (STABLE_CYCLES == 1) begin
            level_d = s2_q;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (s2_q == level_q) begin
          // Bounced back before the run completed: drop the pending change.
          cnt_d   = '0;
          state_d = STABLE;
        end else if (cnt_q == LastCnt) begin
          level_d = s2_q;
          cnt_d   = '0;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = STABLE;
      end
    endcase
  end

  assign level = level_q;

`ifdef DEBOUNCE_AB_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= level_d & ~level_q;
      fall_q <= ~level_d & level_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/debounce_ab.sv
// Two independent debounced inputs feeding the gate stage's a/b inputs.
// Optional edge pulses are enabled by defining DEBOUNCE_AB_EDGE_EN.
module debounce_ab
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W         = DEB_CNT_W,
  parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_ch #(
    .CNT_W        (CNT_W),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_ch_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_a),
    .level(a),
    .rise (a_rise),
    .fall (a_fall)
  );

  debounce_ch #(
    .CNT_W        (CNT_W),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_ch_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_b),
    .level(b),
    .rise (b_rise),
    .fall (b_fall)
  );

endmodule
